fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter FB_W, default 160, framebuffer width in pixels; display scale 4x horizontally.
REQ-002 Parameter FB_H, default 120, framebuffer height in pixels; display scale 4x vertically.
REQ-003 Parameter AW, default 15, memory address width; FB_W*FB_H SHALL fit within 2^AW.
REQ-004 clk  input  1  system clock; twice the pixel rate.
REQ-005 rst  input  1  reset rst, asynchronous, active-high.
REQ-006 pix_en  input  1  one-clk strobe per pixel; x/y advance on the clk after pix_en.
REQ-007 x, y  input  10 each  scan position from the timing generator: 800x525 total, 640x480 active.
REQ-008 wr_req  input  1  drawer write request; held until acknowledged.
REQ-009 wr_addr  input  AW  drawer address, row*FB_W+col.
REQ-010 wr_data  input  3  drawer pixel {R,G,B}.
REQ-011 wr_ack  output  1  one-clk pulse; write committed this cycle.
REQ-012 mem_addr  output  AW  single-port frame memory address.
REQ-013 mem_we  output  1  memory write enable.
REQ-014 mem_wdata  output  3  memory write data.
REQ-015 mem_rdata  input  3  memory read data; valid 1 clk after address.
REQ-016 R_pix, G_pix, B_pix  output  1 each  pixel colour to the timing generator's colour inputs.
REQ-017 busy  output  1  high while a line fetch owns the memory.

Function
REQ-018 FSM states SHALL be IDLE, FETCH and DRAIN; reset state IDLE.
REQ-019 IDLE->FETCH SHALL occur on pix_en with x==640 and either (y<479 and y[1:0]==3) or y==524.
REQ-020 The fetched row SHALL be (y+1)>>2, or 0 when y==524.
REQ-021 In FETCH, read addresses row*FB_W+0 .. row*FB_W+FB_W-1 SHALL issue one per clk.
REQ-022 FETCH->DRAIN SHALL occur after the last address; DRAIN->IDLE SHALL occur one clk later, when the last mem_rdata has been captured.
REQ-023 Each mem_rdata SHALL be written into line-buffer entry col, delayed by one clk to match its address.
REQ-024 A fetch SHALL take FB_W+1 clks, which is within the 320-clk horizontal blanking.
REQ-025 busy SHALL be high in FETCH and DRAIN.
REQ-026 In IDLE with wr_req high, the block SHALL drive mem_we=1, mem_addr=wr_addr and mem_wdata=wr_data, and SHALL pulse wr_ack in the same clk.
REQ-027 wr_ack SHALL stay low in the clk following an ack, allowing at most one write per 2 clks, so the drawer can deassert wr_req.
REQ-028 Fetch SHALL have absolute priority: a wr_req arriving in the trigger clk or during FETCH/DRAIN SHALL wait, and no ack SHALL be given.
REQ-029 wr_addr >= FB_W*FB_H SHALL be acknowledged without asserting mem_we.
REQ-030 The line buffer SHALL be read with index x>>2 while x<640; the output SHALL be registered on pix_en.
REQ-031 Outside the active area the pixel outputs SHALL be 0.
REQ-032 When mem_we=0 and the FSM is IDLE, mem_addr SHALL hold its last value.

Reset
REQ-033 On rst the block SHALL set state=IDLE, col=0, wr_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, R/G/B_pix=0 and busy=0.
REQ-034 Line-buffer contents SHALL be unaffected by reset.
REQ-035 A reset during FETCH SHALL abandon the fetch; the next trigger SHALL restart from col 0.

Structure
REQ-036 A shared package fb_pkg SHALL hold FB_W, FB_H, H_ACTIVE=640, V_ACTIVE=480, H_TOTAL=800, V_TOTAL=525 and the state encodings.
REQ-037 The line buffer SHALL be a sub-module fb_line_buf: 160x3 storage, one synchronous write port, one registered read port.

Verification
REQ-038 After reset with no stimulus -> all outputs 0, busy=0.
REQ-039 pix_en with x=640, y=3 -> busy rises; mem_addr steps 160..319 in 160 consecutive clks; busy falls after 161 clks.
REQ-040 wr_req held high through a fetch starting at y=524 -> no wr_ack during busy; wr_ack and mem_we both occur in the first IDLE clk.
REQ-041 Preload row 0 with pattern col%8 -> on line y=0, the pixel at x=4k+j equals k%8 for j=0..3, and the pixel is 0 at x>=640.
REQ-042 wr_req held high continuously in IDLE -> wr_ack on alternate clks only; wr_addr=19200 -> ack with mem_we=0.
REQ-043 rst asserted mid-FETCH at col 50 -> state IDLE immediately; the next trigger fetches starting from col 0.

Source files
------------

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared constants and FSM state encoding for the framebuffer
//                arbiter. Holds the framebuffer geometry and the 640x480
//                display timing totals.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

  // Framebuffer geometry; the display scales it 4x in each direction
  localparam int FB_W     = 160;
  localparam int FB_H     = 120;

  // Display timing (pixels / lines)
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fb_line_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fb_line_buf
//  Description : One-line pixel buffer. One synchronous write port and one
//                registered read port. Storage is not reset.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk      in   clock
//    rst      in   asynchronous active-high reset (read register only)
//    i_we     in   write enable
//    i_waddr  in   write index
//    i_wdata  in   write pixel {R,G,B}
//    i_raddr  in   read index, sampled every clk
//    o_rdata  out  pixel at i_raddr from the previous clk
// ============================================================================
module fb_line_buf
  import fb_pkg::*;
#(
  parameter int DEPTH = FB_W,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [2:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [2:0]    o_rdata
);

  logic [2:0] r_mem [DEPTH];
  logic [2:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_arbiter
//  Description : Arbitrates a single-port frame memory between a drawing
//                client and the display. During horizontal blanking of every
//                fourth line it fetches the next framebuffer row into a line
//                buffer; otherwise it grants drawer writes (at most one every
//                two clks). The line buffer feeds the 4x-scaled pixel output.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst            clock (2x pixel rate), async active-high reset
//    i_pix_en            one-clk strobe per pixel
//    i_x, i_y            scan position (800x525 total, 640x480 active)
//    i_wr_req            drawer write request, held until acknowledged
//    i_wr_addr           drawer address, row*FB_W+col
//    i_wr_data           drawer pixel {R,G,B}
//    o_wr_ack            one-clk pulse, write committed this clk
//    o_mem_addr          frame memory address
//    o_mem_we            frame memory write enable
//    o_mem_wdata         frame memory write data
//    i_mem_rdata         frame memory read data, 1 clk after address
//    o_r/g/b_pix         pixel colour
//    o_busy              a line fetch owns the memory
// ============================================================================
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int FB_W = fb_pkg::FB_W,
  parameter int FB_H = fb_pkg::FB_H,
  parameter int AW   = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_pix_en,
  input  logic [9:0]    i_x,
  input  logic [9:0]    i_y,
  input  logic          i_wr_req,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [2:0]    i_wr_data,
  output logic          o_wr_ack,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_we,
  output logic [2:0]    o_mem_wdata,
  input  logic [2:0]    i_mem_rdata,
  output logic          o_r_pix,
  output logic          o_g_pix,
  output logic          o_b_pix,
  output logic          o_busy
);

  localparam int                 c_LB_AW    = $clog2(FB_W);
  localparam logic [AW:0]        c_FB_SIZE  = (AW+1)'(FB_W * FB_H);
  localparam logic [c_LB_AW-1:0] c_LAST_COL = c_LB_AW'(FB_W - 1);

  state_t               r_state;
  logic [c_LB_AW-1:0]   r_col;
  logic [AW-1:0]        r_mem_addr;
  logic                 r_mem_we;
  logic [2:0]           r_mem_wdata;
  logic                 r_wr_ack;
  logic                 r_busy;
  logic                 r_lb_we;
  logic [c_LB_AW-1:0]   r_lb_widx;
  logic [2:0]           r_pix;

  logic                 w_trig;
  logic                 w_grant;
  logic                 w_wr_valid;
  logic                 w_x_active;
  logic                 w_active;
  logic [9:0]           w_row;
  logic [AW-1:0]        w_base;
  logic [c_LB_AW-1:0]   w_lb_ridx;
  logic [2:0]           w_lb_rdata;

  // Fetch at the start of horizontal blanking on the last line of each
  // 4-line group, and on the final (invisible) line for row 0.
  assign w_trig = i_pix_en && (i_x == 10'(H_ACTIVE)) &&
                  (((i_y < 10'(V_ACTIVE - 1)) && (i_y[1:0] == 2'd3)) ||
                   (i_y == 10'(V_TOTAL - 1)));

  assign w_row  = (i_y == 10'(V_TOTAL - 1)) ? 10'd0 : ((i_y + 10'd1) >> 2);
  assign w_base = AW'(int'(w_row) * FB_W);

  assign w_wr_valid = ({1'b0, i_wr_addr} < c_FB_SIZE);

  // A grant in DRAIN lands its ack/write in the first IDLE clk. The trigger
  // clk never grants, and the clk after an ack never grants.
  assign w_grant = i_wr_req && !r_wr_ack &&
                   (((r_state == ST_IDLE) && !w_trig) || (r_state == ST_DRAIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_wr_ack    <= 1'b0;
      r_busy      <= 1'b0;
      r_lb_we     <= 1'b0;
      r_lb_widx   <= '0;
    end else begin
      r_mem_we  <= 1'b0;
      r_wr_ack  <= 1'b0;
      // Read data arrives one clk after its address: write it to the
      // column that was addressed in the previous clk.
      r_lb_we   <= (r_state == ST_FETCH);
      r_lb_widx <= r_col;

      case (r_state)
        ST_IDLE: begin
          if (w_trig) begin
            r_state    <= ST_FETCH;
            r_busy     <= 1'b1;
            r_col      <= '0;
            r_mem_addr <= w_base;
          end
        end
        ST_FETCH: begin
          if (r_col == c_LAST_COL) begin
            r_state <= ST_DRAIN;
          end else begin
            r_col      <= r_col + 1'b1;
            r_mem_addr <= r_mem_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_grant) begin
        r_wr_ack <= 1'b1;
        r_mem_we <= w_wr_valid;
        // Out-of-range writes are acknowledged but leave the bus untouched
        if (w_wr_valid) begin
          r_mem_addr  <= i_wr_addr;
          r_mem_wdata <= i_wr_data;
        end
      end
    end
  end

  assign w_x_active = (i_x < 10'(H_ACTIVE));
  assign w_active   = w_x_active && (i_y < 10'(V_ACTIVE));
  assign w_lb_ridx  = w_x_active ? c_LB_AW'(i_x >> 2) : '0;

  fb_line_buf #(
    .DEPTH (FB_W),
    .AW    (c_LB_AW)
  ) u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (r_lb_we),
    .i_waddr (r_lb_widx),
    .i_wdata (i_mem_rdata),
    .i_raddr (w_lb_ridx),
    .o_rdata (w_lb_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix <= '0;
    end else if (i_pix_en) begin
      r_pix <= w_active ? w_lb_rdata : 3'b000;
    end
  end

  assign o_wr_ack    = r_wr_ack;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_we    = r_mem_we;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = r_busy;
  assign o_r_pix     = r_pix[2];
  assign o_g_pix     = r_pix[1];
  assign o_b_pix     = r_pix[0];

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fb_arbiter
//  Description : Self-checking bench for fb_arbiter with a frame memory
//                model and a golden framebuffer image.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_arbiter;

  localparam int FB_W = 160;
  localparam int FB_H = 120;
  localparam int AW   = 15;
  localparam int NPIX = FB_W * FB_H;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_en;
  logic [9:0]    x, y;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;
  logic          wr_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [2:0]    mem_wdata;
  logic [2:0]    mem_rdata;
  logic          r_pix, g_pix, b_pix, busy;

  logic [2:0]    mem  [0:32767];
  logic          wrtn [0:32767];
  logic [2:0]    gold [0:NPIX-1];
  logic [31:0]   seed;

  int n_chk  = 0;
  int n_fail = 0;
  int prev_x, prev_y;
  bit have_prev = 1'b0;

  always #5 clk = ~clk;

  fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_pix_en    (pix_en),
    .i_x         (x),
    .i_y         (y),
    .i_wr_req    (wr_req),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .o_wr_ack    (wr_ack),
    .o_mem_addr  (mem_addr),
    .o_mem_we    (mem_we),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_r_pix     (r_pix),
    .o_g_pix     (g_pix),
    .o_b_pix     (b_pix),
    .o_busy      (busy)
  );

  // Initial frame contents: row 0 holds col%8, the rest a seeded hash
  function automatic logic [2:0] init_val(input int a);
    logic [31:0] h;
    if (a < FB_W) return 3'(a % 8);
    h = 32'(a) * 32'd2654435761 + seed;
    return h[15:13];
  endfunction

  // Single-port frame memory, read data one clk after address
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]  <= mem_wdata;
      wrtn[mem_addr] <= 1'b1;
    end
    mem_rdata <= (wrtn[mem_addr] === 1'b1) ? mem[mem_addr] : init_val(int'(mem_addr));
  end

  function automatic logic [2:0] exp_pix(input int px, input int py);
    if (px < 640 && py < 480) return gold[(py / 4) * FB_W + px / 4];
    return 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},   wr_ack, 0);
    chk({tag, "_we"},    mem_we, 0);
    chk({tag, "_addr"},  mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_pix"},   {r_pix, g_pix, b_pix}, 0);
    chk({tag, "_busy"},  busy, 0);
  endtask

  // Trigger a fetch from line ty; check the address sweep and busy window.
  // abort_col >= 0 resets the DUT when that column is on the bus.
  task automatic fetch_run(input int ty, input int abort_col, input bit with_wr);
    int            base;
    logic [AW-1:0] a;
    logic [2:0]    d;
    base = ((ty == 524) ? 0 : (ty + 1) / 4) * FB_W;
    a = '0;
    d = '0;
    @(negedge clk);
    x = 10'd640; y = 10'(ty); pix_en = 1'b1;
    if (with_wr) begin
      a = AW'($urandom_range(NPIX - 1, 2 * FB_W));
      d = 3'($urandom);
      wr_req = 1'b1; wr_addr = a; wr_data = d;
    end
    @(negedge clk);
    pix_en = 1'b0; x = 10'd641;
    for (int k = 0; k < FB_W; k++) begin
      if (k > 0) @(negedge clk);
      chk("fetch_busy", busy, 1);
      chk("fetch_addr", mem_addr, base + k);
      chk("fetch_we", mem_we, 0);
      if (with_wr) chk("fetch_noack", wr_ack, 0);
      if (k == abort_col) begin
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    @(negedge clk);
    chk("drain_busy", busy, 1);
    if (with_wr) chk("drain_noack", wr_ack, 0);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    if (with_wr) begin
      chk("post_ack", wr_ack, 1);
      chk("post_we", mem_we, 1);
      chk("post_addr", mem_addr, a);
      chk("post_wdata", mem_wdata, d);
      gold[a] = d;
      wr_req = 1'b0;
    end
  endtask

  // Drawer holds wr_req high and presents a new write after every ack
  task automatic write_burst(input int n);
    logic [AW-1:0] a;
    logic [2:0]    d;
    int            j;
    j = 0;
    @(negedge clk);
    x = 10'd641; y = 10'd100; pix_en = 1'b0;
    a = AW'($urandom_range(NPIX - 1, 2 * FB_W));
    d = 3'($urandom);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    for (int i = 1; i <= 2 * n; i++) begin
      @(negedge clk);
      if (i % 2 == 1) begin
        chk("wr_ack", wr_ack, 1);
        chk("wr_we", mem_we, (int'(a) < NPIX) ? 1 : 0);
        if (int'(a) < NPIX) begin
          chk("wr_addr", mem_addr, a);
          chk("wr_wdata", mem_wdata, d);
          gold[a] = d;
        end
        j++;
        if (j == 2)          a = AW'(NPIX);
        else if (j % 5 == 4) a = AW'($urandom_range(32767, NPIX));
        else                 a = AW'($urandom_range(NPIX - 1, 2 * FB_W));
        d = 3'($urandom);
        wr_addr = a; wr_data = d;
      end else begin
        chk("wr_gap_ack", wr_ack, 0);
        chk("wr_gap_we", mem_we, 0);
      end
    end
    wr_req = 1'b0;
  endtask

  // Run one full scan line at one pixel per two clks, checking each pixel
  task automatic scan_line(input int ty);
    for (int px = 0; px < 800; px++) begin
      @(negedge clk);
      pix_en = 1'b0; x = 10'(px); y = 10'(ty);
      if (have_prev) chk("pix", {r_pix, g_pix, b_pix}, exp_pix(prev_x, prev_y));
      @(negedge clk);
      pix_en = 1'b1;
      prev_x = px; prev_y = ty; have_prev = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; x = '0; y = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    seed = $urandom;
    for (int i = 0; i < NPIX; i++) gold[i] = init_val(i);

    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_reset_outputs("idle");

    fetch_run(3, -1, 1'b0);
    fetch_run(524, -1, 1'b1);
    write_burst(12);
    fetch_run(7, 50, 1'b0);
    chk_reset_outputs("after_abort");
    fetch_run(7, -1, 1'b0);

    scan_line(524);
    for (int ln = 0; ln < 8; ln++) scan_line(ln);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
